// File: rtl/glb_sram_pkg.sv
// Shared constants and sizing helpers for the tiled global-buffer bank SRAM.
// Every bank is built from 2048 x 64 macros.
package glb_sram_pkg;

   localparam int MACRO_ADDR_WIDTH = 11;
   localparam int MACRO_DATA_WIDTH = 64;
   localparam int MACRO_DEPTH      = 1 << MACRO_ADDR_WIDTH;

   // Macro rows needed to cover the bank address space.
   function automatic int num_row(input int addr_width);
      return (addr_width > MACRO_ADDR_WIDTH) ? (1 << (addr_width - MACRO_ADDR_WIDTH)) : 1;
   endfunction

   // Macro columns needed to cover the bank word width.
   function automatic int num_col(input int data_width);
      return (data_width + MACRO_DATA_WIDTH - 1) / MACRO_DATA_WIDTH;
   endfunction

   // Width of the row index. It is never narrower than one bit, so that a
   // single-row bank still has a legal row field.
   function automatic int row_width(input int addr_width);
      return (addr_width > MACRO_ADDR_WIDTH) ? (addr_width - MACRO_ADDR_WIDTH) : 1;
   endfunction

endpackage

// File: rtl/glb_sram_row.sv
// One row of 2048x64 macros sharing CEB/WEB/A. D and BWEB are split across the columns.
// Macro model: Q updates one cycle after an enabled read and otherwise holds.
module glb_sram_row
   import glb_sram_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        ceb,
   input  logic                        web,
   input  logic [MACRO_ADDR_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0]       d,
   input  logic [DATA_WIDTH-1:0]       bweb,
   output logic [DATA_WIDTH-1:0]       q
);

   localparam int NUM_COL   = num_col(DATA_WIDTH);
   localparam int BUS_WIDTH = NUM_COL * MACRO_DATA_WIDTH;

   logic [BUS_WIDTH-1:0] d_bus;
   logic [BUS_WIDTH-1:0] bweb_bus;
   logic [BUS_WIDTH-1:0] q_bus;

   // NOTE: every always_comb output gets a full default first so no latch can be inferred.
   always_comb begin
      d_bus                   = '0;
      d_bus[DATA_WIDTH-1:0]   = d;
      // Bits above DATA_WIDTH in the last column stay masked off.
      bweb_bus                 = '1;
      bweb_bus[DATA_WIDTH-1:0] = bweb;
   end

   for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      logic [MACRO_DATA_WIDTH-1:0] mem [MACRO_DEPTH];
      logic [MACRO_DATA_WIDTH-1:0] q_col;
      logic [MACRO_DATA_WIDTH-1:0] d_col;
      logic [MACRO_DATA_WIDTH-1:0] bweb_col;

      assign d_col    = d_bus[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH];
      assign bweb_col = bweb_bus[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH];

      // NOTE: the array and Q are storage, not control state, so they have no reset and keep their contents across reset_n.
      always_ff @(posedge clk) begin
         if (!ceb) begin
            if (!web) begin
               mem[a] <= (mem[a] & bweb_col) | (d_col & ~bweb_col);
            end else begin
               q_col <= mem[a];
            end
         end
      end

      assign q_bus[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH] = q_col;
   end

   assign q = q_bus[DATA_WIDTH-1:0];

endmodule

// File: rtl/glb_bank_sram_array.sv
// Global-buffer bank. 2048x64 macros are tiled by rows and columns, behind a request pipeline
// that can be 0..4 stages deep. The output register is optional, and read-valid is tracked explicitly.
module glb_bank_sram_array
   import glb_sram_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 14,
   parameter int IN_PIPE    = 2,
   parameter int OUT_REG    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_strb,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid
);

   localparam int NUM_ROW   = num_row(ADDR_WIDTH);
   localparam int ROW_WIDTH = row_width(ADDR_WIDTH);

   typedef struct packed {
      logic [NUM_ROW-1:0]          ceb_row;
      logic                        web;
      logic [MACRO_ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0]       d;
      logic [DATA_WIDTH-1:0]       bweb;
      logic [ROW_WIDTH-1:0]        row;
      logic                        is_read;
   } sram_req_t;

   sram_req_t req_s0;
   sram_req_t mac_req;

   logic [ROW_WIDTH-1:0]        addr_row;
   logic [MACRO_ADDR_WIDTH-1:0] addr_macro;

   if (ADDR_WIDTH > MACRO_ADDR_WIDTH) begin : g_multi_row
      assign addr_row   = addr[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
      assign addr_macro = addr[MACRO_ADDR_WIDTH-1:0];
   end else begin : g_single_row
      assign addr_row   = '0;
      assign addr_macro = MACRO_ADDR_WIDTH'(addr);
   end

   // Stage 0 decode. On a simultaneous rd_en/wr_en the write wins.
   always_comb begin
      req_s0         = '0;
      req_s0.ceb_row = '1;
      if (rd_en || wr_en) begin
         req_s0.ceb_row[addr_row] = 1'b0;
      end
      req_s0.web     = ~wr_en;
      req_s0.a       = addr_macro;
      req_s0.d       = wr_data;
      req_s0.bweb    = ~wr_strb;
      req_s0.row     = addr_row;
      req_s0.is_read = rd_en & ~wr_en;
   end

   if (IN_PIPE == 0) begin : g_no_pipe
      assign mac_req = req_s0;
   end else begin : g_pipe
      logic [NUM_ROW-1:0]          ceb_q     [IN_PIPE];
      logic                        web_q     [IN_PIPE];
      logic [ROW_WIDTH-1:0]        row_q     [IN_PIPE];
      logic                        is_read_q [IN_PIPE];
      logic [MACRO_ADDR_WIDTH-1:0] a_q       [IN_PIPE];
      logic [DATA_WIDTH-1:0]       d_q       [IN_PIPE];
      logic [DATA_WIDTH-1:0]       bweb_q    [IN_PIPE];

      // The control stages are reset. Clearing ceb drops any write that has not yet reached the macros.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int s = 0; s < IN_PIPE; s++) begin
               ceb_q[s]     <= '1;
               web_q[s]     <= 1'b1;
               row_q[s]     <= '0;
               is_read_q[s] <= 1'b0;
            end
         end else begin
            ceb_q[0]     <= req_s0.ceb_row;
            web_q[0]     <= req_s0.web;
            row_q[0]     <= req_s0.row;
            is_read_q[0] <= req_s0.is_read;
            for (int s = 1; s < IN_PIPE; s++) begin
               ceb_q[s]     <= ceb_q[s-1];
               web_q[s]     <= web_q[s-1];
               row_q[s]     <= row_q[s-1];
               is_read_q[s] <= is_read_q[s-1];
            end
         end
      end

      // NOTE: the wide payload stages are left unreset because ceb alone decides whether they are used.
      always_ff @(posedge clk) begin
         a_q[0]    <= req_s0.a;
         d_q[0]    <= req_s0.d;
         bweb_q[0] <= req_s0.bweb;
         for (int s = 1; s < IN_PIPE; s++) begin
            a_q[s]    <= a_q[s-1];
            d_q[s]    <= d_q[s-1];
            bweb_q[s] <= bweb_q[s-1];
         end
      end

      assign mac_req = '{
         ceb_row: ceb_q[IN_PIPE-1],
         web:     web_q[IN_PIPE-1],
         a:       a_q[IN_PIPE-1],
         d:       d_q[IN_PIPE-1],
         bweb:    bweb_q[IN_PIPE-1],
         row:     row_q[IN_PIPE-1],
         is_read: is_read_q[IN_PIPE-1]
      };
   end

   logic [DATA_WIDTH-1:0] row_data [NUM_ROW];

   for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
      glb_sram_row #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_row (
         .clk  (clk),
         .ceb  (mac_req.ceb_row[r]),
         .web  (mac_req.web),
         .a    (mac_req.a),
         .d    (mac_req.d),
         .bweb (mac_req.bweb),
         .q    (row_data[r])
      );
   end

   logic [ROW_WIDTH-1:0]  sel_row;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] mux_data;

   // The row select follows read beats only. Writes and idles leave Q alone, so they must not move the mux.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_row <= '0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= mac_req.is_read;
         if (mac_req.is_read) begin
            sel_row <= mac_req.row;
         end
      end
   end

   if (NUM_ROW == 1) begin : g_mux_single
      assign mux_data = row_data[0];
   end else begin : g_mux_multi
      assign mux_data = row_data[sel_row];
   end

   if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
         end else begin
            rd_data_valid <= rd_pend;
            if (rd_pend) begin
               rd_data <= mux_data;
            end
         end
      end
   end else begin : g_out_comb
      assign rd_data       = mux_data;
      assign rd_data_valid = rd_pend;
   end

endmodule
